// File: rtl/tx_frame_sched.sv
// TX symbol sequencer: selects packet framing, SKP/FTS ordered sets and IDLE filler
// for the symbol mux, with SKP scheduling on a fixed interval.
module tx_frame_sched #(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_LEN      = 3,
  parameter int FTS_LEN      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       tlp_req,
  input  logic       dllp_req,
  input  logic [7:0] pkt_len,
  input  logic       pkt_nullify,
  input  logic       fts_req,
  output logic [3:0] control_dk,
  output logic       data_rd,
  output logic       pkt_ack,
  output logic       busy
);

  // state    | meaning
  // S_IDLE   | IDLE filler on output, decision point every cycle
  // S_OS_COM | COM of a SKP/FTS ordered set on output
  // S_OS_SYM | SKP or FTS symbols on output, cnt_q counts down to the last one
  // S_START  | STP/SDP on output, pkt_ack high
  // S_DATA   | payload bytes on output, cnt_q counts down to the last one
  // S_TAIL   | END/EDB on output, decision point

  localparam int OS_MAX = (SKP_LEN > FTS_LEN) ? SKP_LEN : FTS_LEN;
  localparam int CW     = ($clog2(OS_MAX) > 8) ? $clog2(OS_MAX) : 8;
  localparam int SW     = $clog2(SKP_INTERVAL);

  localparam logic [3:0] DK_DATA = 4'd0;
  localparam logic [3:0] DK_COM  = 4'd1;
  localparam logic [3:0] DK_SKP  = 4'd2;
  localparam logic [3:0] DK_STP  = 4'd3;
  localparam logic [3:0] DK_SDP  = 4'd4;
  localparam logic [3:0] DK_END  = 4'd5;
  localparam logic [3:0] DK_EDB  = 4'd6;
  localparam logic [3:0] DK_FTS  = 4'd7;
  localparam logic [3:0] DK_IDLE = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE, S_OS_COM, S_OS_SYM, S_START, S_DATA, S_TAIL
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            os_skp_q, os_skp_d;
  logic            null_q, null_d;
  logic [7:0]      len_q, len_d;
  logic [SW-1:0]   skp_cnt_q;
  logic            skp_pend_q, fts_pend_q;
  logic            skp_wrap;
  logic            clr_skp, clr_fts;
  logic            decide;
  logic            ack_d;
  logic [3:0]      dk_d;

  assign skp_wrap = (skp_cnt_q == SW'(SKP_INTERVAL - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    os_skp_d = os_skp_q;
    null_d   = null_q;
    len_d    = len_q;
    dk_d     = control_dk;
    ack_d    = 1'b0;
    clr_skp  = 1'b0;
    clr_fts  = 1'b0;
    decide   = 1'b0;

    case (state_q)
      S_IDLE: decide = 1'b1;
      S_OS_COM: begin
        state_d = S_OS_SYM;
        cnt_d   = os_skp_q ? CW'(SKP_LEN - 1) : CW'(FTS_LEN - 1);
        dk_d    = os_skp_q ? DK_SKP : DK_FTS;
      end
      S_OS_SYM: begin
        if (cnt_q == '0) decide = 1'b1;
        else cnt_d = cnt_q - 1'b1;
      end
      S_START: begin
        if (len_q == 8'd0) begin
          state_d = S_TAIL;
          dk_d    = null_q ? DK_EDB : DK_END;
        end else begin
          state_d = S_DATA;
          cnt_d   = CW'(len_q) - 1'b1;
          dk_d    = DK_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          state_d = S_TAIL;
          dk_d    = null_q ? DK_EDB : DK_END;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_TAIL: decide = 1'b1;
      default: begin
        state_d = S_IDLE;
        dk_d    = DK_IDLE;
      end
    endcase

    // Last symbol of a unit is on the output: pick the next unit with no gap.
    if (decide) begin
      if (skp_pend_q) begin
        state_d  = S_OS_COM;
        os_skp_d = 1'b1;
        dk_d     = DK_COM;
        clr_skp  = 1'b1;
      end else if (fts_pend_q) begin
        state_d  = S_OS_COM;
        os_skp_d = 1'b0;
        dk_d     = DK_COM;
        clr_fts  = 1'b1;
      end else if (tlp_req || dllp_req) begin
        state_d = S_START;
        dk_d    = tlp_req ? DK_STP : DK_SDP;
        ack_d   = 1'b1;
        len_d   = pkt_len;
        null_d  = pkt_nullify;
      end else begin
        state_d = S_IDLE;
        dk_d    = DK_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      os_skp_q   <= 1'b0;
      null_q     <= 1'b0;
      len_q      <= 8'd0;
      skp_cnt_q  <= '0;
      skp_pend_q <= 1'b0;
      fts_pend_q <= 1'b0;
      control_dk <= DK_IDLE;
      data_rd    <= 1'b0;
      pkt_ack    <= 1'b0;
      busy       <= 1'b0;
    end else if (enb) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      os_skp_q   <= os_skp_d;
      null_q     <= null_d;
      len_q      <= len_d;
      skp_cnt_q  <= skp_wrap ? '0 : skp_cnt_q + 1'b1;
      // A wrap on the clearing cycle keeps the SKP pending; same for a new fts_req.
      skp_pend_q <= (skp_pend_q && !clr_skp) || skp_wrap;
      fts_pend_q <= (fts_pend_q && !clr_fts) || fts_req;
      control_dk <= dk_d;
      data_rd    <= (dk_d == DK_DATA);
      pkt_ack    <= ack_d;
      busy       <= (dk_d != DK_IDLE);
    end else begin
      data_rd <= 1'b0;
      pkt_ack <= 1'b0;
    end
  end

endmodule
